ram_arbiter: RTL and testbench

//  Shares the single-port instruction/data RAM between the IF stage (instruction fetch)
//  and the MEM stage (LW/SW). It sequences each RAM access with OE/WE timing, gives the
//  MEM stage priority, and stalls the losing stage until its access completes.

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/ram_arb_ibuf.sv | 56 +++++
 rtl/ram_arbiter.sv | 147 ++++++++++++++
 tb/tb_ram_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
// Holds the arbiter FSM encoding, wait-counter width and the reset NOP word.
// Imported by ram_arbiter and ram_arb_ibuf.
package ram_arbiter_pkg;

    localparam int          CNT_W    = 3;
    localparam logic [15:0] NOP_INST = 16'h0800;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_ACC_IF = 3'd1,
        ARB_ACC_RD = 3'd2,
        ARB_ACC_WR = 3'd3,
        ARB_DONE   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/ram_arb_ibuf.sv
// One-entry instruction fetch buffer (tag = pc, data, valid) with hit compare.
// Lookup is combinational; fill and invalidate take effect on the next cycle.
// No backpressure: the arbiter decides when to fill, invalidate or use a hit.
module ram_arb_ibuf
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_tag_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic              inval_i,
    input  logic [ADDR_W-1:0] inval_addr_i
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Refill on every RAM fetch; a store that hits the tag kills the entry.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = fill_tag_i;
            data_d  = fill_data_i;
        end else if (inval_i && (inval_addr_i == tag_q)) begin
            valid_d = 1'b0;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_pc_i);
    assign data_o = data_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between IF fetches and MEM loads/stores, MEM first.
// Latency: accept n, access n+1..n+1+WAIT_CYCLES, done pulse n+2+WAIT_CYCLES.
// Losing/waiting requester is stalled; RAM_ARB_IBUF_EN adds a one-entry fetch buffer.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    output logic [DATA_W-1:0] if_inst_o,
    output logic              if_done_o,
    output logic              if_stall_o,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    output logic              mem_stall_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              ram_oe_o,
    output logic              ram_we_o
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              src_if_q, src_if_d;
    logic              buf_hit;
    logic [DATA_W-1:0] buf_data;

`ifdef RAM_ARB_IBUF_EN
    ram_arb_ibuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ibuf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .lookup_pc_i  (if_pc_i),
        .hit_o        (buf_hit),
        .data_o       (buf_data),
        .fill_i       ((state_q == ARB_ACC_IF) && (cnt_q == '0)),
        .fill_tag_i   (addr_q),
        .fill_data_i  (ram_rdata_i),
        .inval_i      ((state_q == ARB_IDLE) && mem_wr_i),
        .inval_addr_i (mem_addr_i)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    // State register; reset drops any in-flight access.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    // Next state plus latched bus/data values; MEM beats IF, DONE is a turnaround.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        src_if_d    = src_if_q;
        case (state_q)
            ARB_IDLE: begin
                if (mem_rd_i || mem_wr_i) begin
                    state_d  = mem_wr_i ? ARB_ACC_WR : ARB_ACC_RD;
                    addr_d   = mem_addr_i;
                    wdata_d  = mem_wdata_i;
                    cnt_d    = WAIT_CNT;
                    src_if_d = 1'b0;
                end else if (if_req_i) begin
                    src_if_d = 1'b1;
                    if (buf_hit) begin
                        state_d   = ARB_DONE;
                        if_inst_d = buf_data;
                    end else begin
                        state_d = ARB_ACC_IF;
                        addr_d  = if_pc_i;
                        cnt_d   = WAIT_CNT;
                    end
                end
            end
            ARB_ACC_IF, ARB_ACC_RD, ARB_ACC_WR: begin
                if (cnt_q == '0) begin
                    state_d = ARB_DONE;
                    if (state_q == ARB_ACC_IF) if_inst_d   = ram_rdata_i;
                    if (state_q == ARB_ACC_RD) mem_rdata_d = ram_rdata_i;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Datapath registers: bus address/data, wait counter, returned data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_inst_q   <= DATA_W'(NOP_INST);
            mem_rdata_q <= '0;
            src_if_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
            src_if_q    <= src_if_d;
        end
    end

    // Strobes from state: OE on every read cycle, WE skips the first write cycle.
    always_comb begin
        ram_oe_o   = (state_q == ARB_ACC_IF) || (state_q == ARB_ACC_RD);
        ram_we_o   = (state_q == ARB_ACC_WR) && ((WAIT_CNT == '0) || (cnt_q != WAIT_CNT));
        if_done_o  = (state_q == ARB_DONE) && src_if_q;
        mem_done_o = (state_q == ARB_DONE) && !src_if_q;
    end

    assign if_stall_o  = if_req_i && !if_done_o;
    assign mem_stall_o = (mem_rd_i || mem_wr_i) && !mem_done_o;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign if_inst_o   = if_inst_q;
    assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (WAIT_CYCLES=1) with a small preloaded RAM model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Define RAM_ARB_IBUF_EN to exercise the fetch-buffer build.
module tb_ram_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req, mem_rd, mem_wr;
    logic [15:0] if_pc, mem_addr, mem_wdata;
    logic [15:0] if_inst, mem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_done, if_stall, mem_done, mem_stall, ram_oe, ram_we;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] oe_v, we_v, ifd_v, memd_v, ifs_v, mems_v;
    logic [15:0] got_inst, got_rdata;

    // RAM model: preload pattern until a location is written.
    logic [15:0] wmem [0:255];
    bit          wvalid [0:255];
    logic [7:0]  ram_a;

    function automatic logic [15:0] pre_val(input logic [7:0] a);
        case (a)
            8'h01:   return 16'h1111;
            8'h02:   return 16'h2222;
            8'h03:   return 16'h6802;
            8'h05:   return 16'h5555;
            default: return {8'hEE, a};
        endcase
    endfunction

    assign ram_a     = ram_addr[7:0];
    assign ram_rdata = wvalid[ram_a] ? wmem[ram_a] : pre_val(ram_a);

    always @(posedge clk_i) begin
        if (ram_we) begin
            wmem[ram_a]   <= ram_wdata;
            wvalid[ram_a] <= 1'b1;
        end
    end

    always #5 clk_i = ~clk_i;

    ram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16), .DATA_W(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req),
        .if_pc_i     (if_pc),
        .if_inst_o   (if_inst),
        .if_done_o   (if_done),
        .if_stall_o  (if_stall),
        .mem_rd_i    (mem_rd),
        .mem_wr_i    (mem_wr),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .mem_done_o  (mem_done),
        .mem_stall_o (mem_stall),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .ram_oe_o    (ram_oe),
        .ram_we_o    (ram_we)
    );

    // Runs n cycles from the current cycle (cycle 0), records per-cycle strobes,
    // and drops each request the cycle after its done pulse.
    task automatic run_cycles(input int n);
        bit drop_if, drop_mem;
        oe_v = '0; we_v = '0; ifd_v = '0; memd_v = '0; ifs_v = '0; mems_v = '0;
        drop_if = 0; drop_mem = 0;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(posedge clk_i); #1;
            end
            if (drop_if) if_req = 1'b0;
            if (drop_mem) begin mem_rd = 1'b0; mem_wr = 1'b0; end
            drop_if = 0; drop_mem = 0;
            @(negedge clk_i);
            oe_v[c] = ram_oe; we_v[c] = ram_we; ifd_v[c] = if_done;
            memd_v[c] = mem_done; ifs_v[c] = if_stall; mems_v[c] = mem_stall;
            if (if_done)  begin drop_if = 1;  got_inst  = if_inst;   end
            if (mem_done) begin drop_mem = 1; got_rdata = mem_rdata; end
        end
        if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; if_req = 0; mem_rd = 0; mem_wr = 0;
        if_pc = '0; mem_addr = '0; mem_wdata = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        vectors++; if ({ram_oe, ram_we, if_done, mem_done} !== 4'b0000) begin miscompares++; $display("FAIL reset_strobes got %b want 0000", {ram_oe, ram_we, if_done, mem_done}); end
        vectors++; if (if_inst !== 16'h0800) begin miscompares++; $display("FAIL reset_if_inst got %h want 0800", if_inst); end
        vectors++; if (mem_rdata !== 16'h0000) begin miscompares++; $display("FAIL reset_mem_rdata got %h want 0000", mem_rdata); end
        vectors++; if ({ram_addr, ram_wdata} !== 32'h0) begin miscompares++; $display("FAIL reset_bus got %h want 0", {ram_addr, ram_wdata}); end
        @(posedge clk_i); #1 rst_i = 1'b0;
    endtask

    task automatic test_fetch();
        @(posedge clk_i); #1;
        if_req = 1'b1; if_pc = 16'h0003;
        run_cycles(6);
        vectors++; if (oe_v !== 16'h0006) begin miscompares++; $display("FAIL fetch_oe got %h want 0006", oe_v); end
        vectors++; if (ifd_v !== 16'h0008) begin miscompares++; $display("FAIL fetch_done got %h want 0008", ifd_v); end
        vectors++; if (ifs_v !== 16'h0007) begin miscompares++; $display("FAIL fetch_stall got %h want 0007", ifs_v); end
        vectors++; if (got_inst !== 16'h6802) begin miscompares++; $display("FAIL fetch_inst got %h want 6802", got_inst); end
        vectors++; if (memd_v !== 16'h0000) begin miscompares++; $display("FAIL fetch_memdone got %h want 0000", memd_v); end
    endtask

    task automatic test_conflict();
        @(posedge clk_i); #1;
        if_req = 1'b1; if_pc = 16'h0002; mem_rd = 1'b1; mem_addr = 16'h0001;
        run_cycles(10);
        vectors++; if (memd_v !== 16'h0008) begin miscompares++; $display("FAIL conflict_memdone got %h want 0008", memd_v); end
        vectors++; if (ifd_v !== 16'h0080) begin miscompares++; $display("FAIL conflict_ifdone got %h want 0080", ifd_v); end
        vectors++; if (ifs_v !== 16'h007F) begin miscompares++; $display("FAIL conflict_ifstall got %h want 007f", ifs_v); end
        vectors++; if (mems_v !== 16'h0007) begin miscompares++; $display("FAIL conflict_memstall got %h want 0007", mems_v); end
        vectors++; if (oe_v !== 16'h0066) begin miscompares++; $display("FAIL conflict_oe got %h want 0066", oe_v); end
        vectors++; if (got_rdata !== 16'h1111) begin miscompares++; $display("FAIL conflict_rdata got %h want 1111", got_rdata); end
        vectors++; if (got_inst !== 16'h2222) begin miscompares++; $display("FAIL conflict_inst got %h want 2222", got_inst); end
    endtask

    task automatic test_store();
        @(posedge clk_i); #1;
        mem_wr = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'hBEEF;
        run_cycles(5);
        vectors++; if (we_v !== 16'h0004) begin miscompares++; $display("FAIL store_we got %h want 0004", we_v); end
        vectors++; if (oe_v !== 16'h0000) begin miscompares++; $display("FAIL store_oe got %h want 0000", oe_v); end
        vectors++; if (memd_v !== 16'h0008) begin miscompares++; $display("FAIL store_done got %h want 0008", memd_v); end
        @(posedge clk_i); #1;
        mem_rd = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'h0000;
        run_cycles(5);
        vectors++; if (got_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL store_readback got %h want beef", got_rdata); end
        vectors++; if (we_v !== 16'h0000) begin miscompares++; $display("FAIL load_we got %h want 0000", we_v); end
    endtask

    task automatic test_rd_wr_both();
        @(posedge clk_i); #1;
        mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h1234;
        run_cycles(5);
        vectors++; if (we_v !== 16'h0004) begin miscompares++; $display("FAIL both_we got %h want 0004", we_v); end
        vectors++; if (oe_v !== 16'h0000) begin miscompares++; $display("FAIL both_oe got %h want 0000", oe_v); end
        vectors++; if (!wvalid[8'h20] || wmem[8'h20] !== 16'h1234) begin miscompares++; $display("FAIL both_ram got %h want 1234", wmem[8'h20]); end
        @(posedge clk_i); #1;
        mem_rd = 1'b1; mem_addr = 16'h0020;
        run_cycles(5);
        vectors++; if (got_rdata !== 16'h1234) begin miscompares++; $display("FAIL both_readback got %h want 1234", got_rdata); end
    endtask

    task automatic test_refetch();
        @(posedge clk_i); #1; if_req = 1'b1; if_pc = 16'h0005;
        run_cycles(6);
        vectors++; if (got_inst !== 16'h5555) begin miscompares++; $display("FAIL refetch1_inst got %h want 5555", got_inst); end
        @(posedge clk_i); #1; if_req = 1'b1; if_pc = 16'h0005;
        run_cycles(6);
`ifdef RAM_ARB_IBUF_EN
        vectors++; if (oe_v !== 16'h0000) begin miscompares++; $display("FAIL refetch2_oe got %h want 0000", oe_v); end
        vectors++; if (ifd_v !== 16'h0002) begin miscompares++; $display("FAIL refetch2_done got %h want 0002", ifd_v); end
`else
        vectors++; if (oe_v !== 16'h0006) begin miscompares++; $display("FAIL refetch2_oe got %h want 0006", oe_v); end
        vectors++; if (ifd_v !== 16'h0008) begin miscompares++; $display("FAIL refetch2_done got %h want 0008", ifd_v); end
`endif
        vectors++; if (got_inst !== 16'h5555) begin miscompares++; $display("FAIL refetch2_inst got %h want 5555", got_inst); end
        @(posedge clk_i); #1; mem_wr = 1'b1; mem_addr = 16'h0005; mem_wdata = 16'hABCD;
        run_cycles(5);
        @(posedge clk_i); #1; if_req = 1'b1; if_pc = 16'h0005;
        run_cycles(6);
        vectors++; if (oe_v !== 16'h0006) begin miscompares++; $display("FAIL refetch3_oe got %h want 0006", oe_v); end
        vectors++; if (ifd_v !== 16'h0008) begin miscompares++; $display("FAIL refetch3_done got %h want 0008", ifd_v); end
        vectors++; if (got_inst !== 16'hABCD) begin miscompares++; $display("FAIL refetch3_inst got %h want abcd", got_inst); end
    endtask

    task automatic test_reset_mid_access();
        logic seen_done;
        @(posedge clk_i); #1; mem_rd = 1'b1; mem_addr = 16'h0001;
        @(posedge clk_i); #1; rst_i = 1'b1;
        @(negedge clk_i);
        vectors++; if (ram_oe !== 1'b1) begin miscompares++; $display("FAIL midrst_oe_before got %b want 1", ram_oe); end
        @(posedge clk_i); #1; rst_i = 1'b0; mem_rd = 1'b0;
        @(negedge clk_i);
        vectors++; if ({ram_oe, ram_we, mem_done, if_done} !== 4'b0000) begin miscompares++; $display("FAIL midrst_strobes got %b want 0000", {ram_oe, ram_we, mem_done, if_done}); end
        vectors++; if (if_inst !== 16'h0800) begin miscompares++; $display("FAIL midrst_if_inst got %h want 0800", if_inst); end
        vectors++; if (mem_rdata !== 16'h0000) begin miscompares++; $display("FAIL midrst_mem_rdata got %h want 0000", mem_rdata); end
        vectors++; if (ram_addr !== 16'h0000) begin miscompares++; $display("FAIL midrst_addr got %h want 0000", ram_addr); end
        seen_done = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            seen_done = seen_done | mem_done | ram_oe;
        end
        vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL midrst_no_done got %b want 0", seen_done); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_conflict();
        test_store();
        test_rd_wr_both();
        test_refetch();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
